// File: rtl/line_buffer_ctrl.sv
// Write/read controller for the four-line pixel buffer bank.
// Incoming raster pixels are written round-robin into four line buffers. Once
// three full lines are stored, three buffers are read in lockstep and one 3x3
// window per cycle is registered out to the convolution stage. o_intr pulses
// once per consumed line so the host can send another.
//
// Handshake: a pixel is transferred on a clock edge where i_pixel_valid=1 and
// o_ready=1. A valid pixel presented while o_ready=0 is dropped, not held; the
// source must re-present it. o_window_valid qualifies o_window for one cycle
// per window and has no back-pressure.
module line_buffer_ctrl #(
  parameter  int SIZE        = 8,
  localparam int IMAGE_WIDTH = 512,
  localparam int FILL_W      = $clog2(4 * IMAGE_WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [SIZE-1:0]     i_pixel_data,
  input  logic                i_pixel_valid,
  output logic                o_ready,
  output logic [SIZE-1:0]     o_lb_wr_data,
  output logic [3:0]          o_lb_wr_en,
  output logic [3:0]          o_lb_rd_en,
  input  logic [3*SIZE-1:0]   i_lb_rd_data0,
  input  logic [3*SIZE-1:0]   i_lb_rd_data1,
  input  logic [3*SIZE-1:0]   i_lb_rd_data2,
  input  logic [3*SIZE-1:0]   i_lb_rd_data3,
  output logic [9*SIZE-1:0]   o_window,
  output logic                o_window_valid,
  output logic                o_intr,
  output logic [0:0]          o_dbg_state,
  output logic [FILL_W-1:0]   o_dbg_fill
);

  localparam int CNT_W = $clog2(IMAGE_WIDTH);

  localparam logic [CNT_W-1:0]  LAST_PIX   = CNT_W'(IMAGE_WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(4 * IMAGE_WIDTH);
  localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * IMAGE_WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [1:0]        wr_sel_q, wr_sel_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [1:0]        rd_sel_q, rd_sel_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [0:0]        state_q, state_d;
  logic [9*SIZE-1:0] window_q, window_d;
  logic              window_valid_q, window_valid_d;
  logic              intr_q, intr_d;

  logic              wr;
  logic              rd;
  logic [1:0]        rd_sel_p1;
  logic [1:0]        rd_sel_p2;
  logic [3*SIZE-1:0] rd_data [4];

  assign rd_data[0] = i_lb_rd_data0;
  assign rd_data[1] = i_lb_rd_data1;
  assign rd_data[2] = i_lb_rd_data2;
  assign rd_data[3] = i_lb_rd_data3;

  // The three read lines are consecutive buffers, wrapping modulo four.
  assign rd_sel_p1 = rd_sel_q + 2'd1;
  assign rd_sel_p2 = rd_sel_q + 2'd2;

  assign o_ready = (fill_q < FILL_FULL);
  assign wr      = i_pixel_valid & o_ready;
  assign rd      = (state_q == ST_READ);

  // Buffer strobes are gated by rstN so nothing is written or advanced during reset.
  always_comb begin
    o_lb_wr_en = 4'b0000;
    o_lb_rd_en = 4'b0000;
    if (rstN && wr) begin
      o_lb_wr_en = 4'b0001 << wr_sel_q;
    end
    if (rstN && rd) begin
      o_lb_rd_en = (4'b0001 << rd_sel_q) | (4'b0001 << rd_sel_p1) | (4'b0001 << rd_sel_p2);
    end
  end

  assign o_lb_wr_data   = i_pixel_data;
  assign o_window       = window_q;
  assign o_window_valid = window_valid_q;
  assign o_intr         = intr_q;
  assign o_dbg_state    = state_q;
  assign o_dbg_fill     = fill_q;

  // Next-state logic: write pointer, occupancy, read FSM and window register.
  always_comb begin
    wr_cnt_d       = wr_cnt_q;
    wr_sel_d       = wr_sel_q;
    rd_cnt_d       = rd_cnt_q;
    rd_sel_d       = rd_sel_q;
    fill_d         = fill_q;
    state_d        = state_q;
    window_d       = window_q;
    window_valid_d = rd;
    intr_d         = 1'b0;

    if (wr) begin
      if (wr_cnt_q == LAST_PIX) begin
        wr_cnt_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // A write and a read in the same cycle cancel out.
    case ({wr, rd})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    // The start test looks at the post-update fill so a read begins the cycle
    // right after the write that completes the third line.
    case (state_q)
      ST_IDLE: begin
        if (fill_d >= FILL_START) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == LAST_PIX) begin
          rd_cnt_d = '0;
          rd_sel_d = rd_sel_q + 2'd1;
          state_d  = ST_IDLE;
          intr_d   = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Oldest line is the top row; the window holds its value between reads.
    if (rd) begin
      window_d = {rd_data[rd_sel_q], rd_data[rd_sel_p1], rd_data[rd_sel_p2]};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_cnt_q       <= '0;
      wr_sel_q       <= '0;
      rd_cnt_q       <= '0;
      rd_sel_q       <= '0;
      fill_q         <= '0;
      state_q        <= ST_IDLE;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      intr_q         <= 1'b0;
    end else begin
      wr_cnt_q       <= wr_cnt_d;
      wr_sel_q       <= wr_sel_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_sel_q       <= rd_sel_d;
      fill_q         <= fill_d;
      state_q        <= state_d;
      window_q       <= window_d;
      window_valid_q <= window_valid_d;
      intr_q         <= intr_d;
    end
  end

endmodule
